// File: rtl/vga_sync_gen_pkg.sv
// Default 640x480@60 timing for the VGA raster generator, plus the sync-polarity helper.
package vga_sync_gen_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_CNT_W    = 10;
  localparam int unsigned VGA_CLK_DIV  = 4;

  localparam int unsigned VGA_H_TOTAL    = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL    = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned VGA_HS_START   = VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_HS_END     = VGA_HS_START + VGA_H_SYNC;
  localparam int unsigned VGA_VS_START   = VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VGA_VS_END     = VGA_VS_START + VGA_V_SYNC;

  // Maps a logical "pulse asserted" onto the pin level for the chosen polarity.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_sync_gen_axis_counter.sv
// vga_axis_counter: one raster axis counting 0..MAX while en is high; parks at MAX in reset
// so the first enabled step lands on 0.
module vga_axis_counter
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned CNT_W = VGA_CNT_W,
  parameter int unsigned MAX   = VGA_H_TOTAL - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    wrap  = en && (cnt_q == MAX_C);
    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The next value is exported so the top can register its decode in the same edge.
  assign cnt_nxt = cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= MAX_C;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing (hsync/vsync, active, x/y, line/frame strobes).
// Optional VGA_CLK_DIV_EN: clk runs CLK_DIV times the pixel rate and an internal prescaler gates the raster.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CNT_W    = VGA_CNT_W,
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic             pixel_tick
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if ((CNT_W < $clog2(H_TOTAL)) || (CNT_W < $clog2(V_TOTAL)) || (CLK_DIV < 1)) begin : g_bad_cfg
    $error("vga_sync_gen: CNT_W too narrow for the raster, or CLK_DIV below 1");
  end

  logic tick;

`ifdef VGA_CLK_DIV_EN
  localparam int unsigned      PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  // Tick on the prescaler wrap, so the first raster step is CLK_DIV clks after release.
  always_comb begin
    tick  = (pre_q == PRE_MAX);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;
  logic             v_wrap;

  vga_axis_counter #(.CNT_W(CNT_W), .MAX(H_TOTAL - 1)) u_h_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (tick),
    .cnt_nxt (h_nxt),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(.CNT_W(CNT_W), .MAX(V_TOTAL - 1)) u_v_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (h_wrap),
    .cnt_nxt (v_nxt),
    .wrap    (v_wrap)
  );

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             active_q, active_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             pixel_tick_q, pixel_tick_d;

  // Decode the post-tick counter values so every output flop lands on the same edge.
  always_comb begin
    x_d           = h_nxt;
    y_d           = v_nxt;
    active_d      = (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
    hsync_d       = sync_level((h_nxt >= HS_START_C) && (h_nxt < HS_END_C), SYNC_POL);
    vsync_d       = sync_level((v_nxt >= VS_START_C) && (v_nxt < VS_END_C), SYNC_POL);
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
    pixel_tick_d  = tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= sync_level(1'b0, SYNC_POL);
      vsync_q       <= sync_level(1'b0, SYNC_POL);
      active_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_tick_q  <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      pixel_tick_q  <= pixel_tick_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign pixel_tick  = pixel_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a 640x480 instance and a small active-high-sync instance
// share clk/rst_n; a tick-count reference model predicts every raster position.
`timescale 1ns/1ps
module tb_vga_sync_gen;

`ifdef VGA_CLK_DIV_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  localparam int BHA = 16, BHF = 4, BHS = 6, BHB = 5;
  localparam int BVA = 12, BVF = 2, BVS = 2, BVB = 3;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_hs, a_vs, a_act, a_ls, a_fs, a_pt;
  logic [9:0] a_x, a_y;
  logic       b_hs, b_vs, b_act, b_ls, b_fs, b_pt;
  logic [9:0] b_x, b_y;

  vga_sync_gen #(.CLK_DIV(DIV)) u_a (
    .clk(clk), .rst_n(rst_n), .hsync(a_hs), .vsync(a_vs), .active(a_act),
    .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs), .pixel_tick(a_pt)
  );

  vga_sync_gen #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .SYNC_POL(1'b1), .CNT_W(10), .CLK_DIV(DIV)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .hsync(b_hs), .vsync(b_vs), .active(b_act),
    .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs), .pixel_tick(b_pt)
  );

  obs_t a_obs, b_obs;
  assign a_obs = {a_hs, a_vs, a_act, a_x, a_y, a_ls, a_fs};
  assign b_obs = {b_hs, b_vs, b_act, b_x, b_y, b_ls, b_fs};

  int n_tests = 0;
  int n_fail  = 0;

  // Raster position after t pixel ticks, straight from line/frame arithmetic.
  function automatic obs_t model(int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb,
                                 bit pol, int t);
    obs_t o;
    int ht, vt, h, v;
    ht    = ha + hf + hs + hb;
    vt    = va + vf + vs + vb;
    h     = t % ht;
    v     = (t / ht) % vt;
    o.x   = 10'(h);
    o.y   = 10'(v);
    o.act = (h < ha) && (v < va);
    o.hs  = ((h >= ha + hf) && (h < ha + hf + hs)) ? pol : !pol;
    o.vs  = ((v >= va + vf) && (v < va + vf + vs)) ? pol : !pol;
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic obs_t rst_obs(bit pol);
    obs_t o;
    o    = '0;
    o.hs = !pol;
    o.vs = !pol;
    return o;
  endfunction

  task automatic cmp(input string nm, input obs_t got, input logic got_pt,
                     input obs_t exp, input logic exp_pt);
    n_tests++;
    if (got !== exp || got_pt !== exp_pt) begin
      n_fail++;
      $display("FAIL %s @%0t got x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b pt=%b required x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b pt=%b",
               nm, $time, got.x, got.y, got.hs, got.vs, got.act, got.ls, got.fs, got_pt,
               exp.x, exp.y, exp.hs, exp.vs, exp.act, exp.ls, exp.fs, exp_pt);
    end
  endtask

  task automatic cmp_int(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t got %0d required %0d", nm, $time, got, exp);
    end
  endtask

  obs_t qa[$];
  obs_t qb[$];
  int   clks  = 0;
  int   ticks = 0;

  // Reference model: one expected raster position per predicted pixel tick.
  always @(posedge clk) begin
    if (!rst_n) begin
      clks  = 0;
      ticks = 0;
    end else begin
      clks++;
      if (clks % DIV == 0) begin
        qa.push_back(model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, ticks));
        qb.push_back(model(BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1'b1, ticks));
        ticks++;
      end
    end
  end

  obs_t hold_a, hold_b;

  always @(negedge clk) begin
    obs_t e;
    if (!rst_n) begin
      hold_a = rst_obs(1'b0);
      cmp("a_reset", a_obs, a_pt, hold_a, 1'b0);
    end else if (a_pt) begin
      if (qa.size() == 0) begin
        cmp_int("a_unexpected_tick", 1, 0);
      end else begin
        e = qa.pop_front();
        cmp("a_tick", a_obs, a_pt, e, 1'b1);
        hold_a    = e;
        hold_a.ls = 1'b0;
        hold_a.fs = 1'b0;
      end
    end else begin
      cmp("a_hold", a_obs, a_pt, hold_a, 1'b0);
    end
  end

  always @(negedge clk) begin
    obs_t e;
    if (!rst_n) begin
      hold_b = rst_obs(1'b1);
      cmp("b_reset", b_obs, b_pt, hold_b, 1'b0);
    end else if (b_pt) begin
      if (qb.size() == 0) begin
        cmp_int("b_unexpected_tick", 1, 0);
      end else begin
        e = qb.pop_front();
        cmp("b_tick", b_obs, b_pt, e, 1'b1);
        hold_b    = e;
        hold_b.ls = 1'b0;
        hold_b.fs = 1'b0;
      end
    end else begin
      cmp("b_hold", b_obs, b_pt, hold_b, 1'b0);
    end
  end

  task automatic pulse_reset(input int len);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    cmp("a_async_reset", a_obs, a_pt, rst_obs(1'b0), 1'b0);
    cmp("b_async_reset", b_obs, b_pt, rst_obs(1'b1), 1'b0);
    cmp_int("a_missed_ticks", qa.size(), 0);
    cmp_int("b_missed_ticks", qb.size(), 0);
    qa.delete();
    qb.delete();
    repeat (len) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3000) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      pulse_reset(int'($urandom_range(1, 3)));
      repeat ($urandom_range(500, 3000)) @(negedge clk);
    end
    repeat (14000) @(negedge clk);
    #1;
    cmp_int("a_leftover_ticks", qa.size(), 0);
    cmp_int("b_leftover_ticks", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
